// File: rtl/segment_scheduler.sv
// Per-frame line-segment scheduler: snapshots bird/pipe coordinates, requests a clear,
// then streams one vertical segment per valid/ready handshake to the line drawer.
module segment_scheduler #(
    parameter int N         = 11,
    parameter int NUM_PIPES = 3,
    parameter int PIPE_W    = 4,
    parameter int X_MAX     = 639
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   frame_start,
    input  logic [NUM_PIPES*N-1:0] pipe_x,
    input  logic [NUM_PIPES*N-1:0] pipe_gap_top,
    input  logic [NUM_PIPES*N-1:0] pipe_gap_bot,
    input  logic [N-1:0]           y_top,
    input  logic [N-1:0]           y_bot,
    input  logic [N-1:0]           bird_x,
    input  logic [N-1:0]           bird_y0,
    input  logic [N-1:0]           bird_y1,
    output logic                   clear_req,
    input  logic                   clear_done,
    output logic                   seg_valid,
    input  logic                   seg_ready,
    output logic [N-1:0]           x0,
    output logic [N-1:0]           y0,
    output logic [N-1:0]           x1,
    output logic [N-1:0]           y1,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int KW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
    localparam int CW = (PIPE_W > 1) ? $clog2(PIPE_W) : 1;

    typedef enum logic [2:0] {
        IDLE, CLEAR, BIRD, PIPE_TOP, PIPE_BOT, DONE
    } state_t;

    state_t state, state_n;

    logic [N-1:0] px_q [NUM_PIPES];
    logic [N-1:0] gt_q [NUM_PIPES];
    logic [N-1:0] gb_q [NUM_PIPES];
    logic [N-1:0] yt_q, yb_q, bx_q, by0_q, by1_q;

    logic [KW-1:0] k, k_n;
    logic [CW-1:0] c, c_n;
    logic          seg_valid_n;
    logic [N-1:0]  x0_n, y0_n, x1_n, y1_n;
    logic          load, step;
    logic [N:0]    col;
    logic          off;

    // Column is computed one bit wider so wrap-around lands off-screen.
    assign col = {1'b0, px_q[k]} + (N+1)'(c);
    assign off = col > (N+1)'(X_MAX);

    assign clear_req  = (state == CLEAR);
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    always_comb begin
        state_n     = state;
        k_n         = k;
        c_n         = c;
        seg_valid_n = seg_valid;
        x0_n        = x0;
        y0_n        = y0;
        x1_n        = x1;
        y1_n        = y1;
        load        = 1'b0;
        step        = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_start) begin
                    load    = 1'b1;
                    state_n = CLEAR;
                end
            end
            CLEAR: begin
                if (clear_done) state_n = BIRD;
            end
            BIRD: begin
                if (!seg_valid) begin
                    seg_valid_n = 1'b1;
                    x0_n = bx_q;
                    y0_n = by0_q;
                    x1_n = bx_q;
                    y1_n = by1_q;
                end else if (seg_ready) begin
                    seg_valid_n = 1'b0;
                    k_n     = '0;
                    c_n     = '0;
                    state_n = PIPE_TOP;
                end
            end
            PIPE_TOP: begin
                if (!seg_valid) begin
                    if (off || gt_q[k] < yt_q) begin
                        state_n = PIPE_BOT;
                    end else begin
                        seg_valid_n = 1'b1;
                        x0_n = col[N-1:0];
                        y0_n = yt_q;
                        x1_n = col[N-1:0];
                        y1_n = gt_q[k];
                    end
                end else if (seg_ready) begin
                    seg_valid_n = 1'b0;
                    state_n     = PIPE_BOT;
                end
            end
            PIPE_BOT: begin
                if (!seg_valid) begin
                    if (off || gb_q[k] > yb_q) begin
                        step = 1'b1;
                    end else begin
                        seg_valid_n = 1'b1;
                        x0_n = col[N-1:0];
                        y0_n = gb_q[k];
                        x1_n = col[N-1:0];
                        y1_n = yb_q;
                    end
                end else if (seg_ready) begin
                    seg_valid_n = 1'b0;
                    step        = 1'b1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (step) begin
            if (c == CW'(PIPE_W - 1)) begin
                c_n = '0;
                if (k == KW'(NUM_PIPES - 1)) begin
                    state_n = DONE;
                end else begin
                    k_n     = k + 1'b1;
                    state_n = PIPE_TOP;
                end
            end else begin
                c_n     = c + 1'b1;
                state_n = PIPE_TOP;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            k         <= '0;
            c         <= '0;
            seg_valid <= 1'b0;
            x0        <= '0;
            y0        <= '0;
            x1        <= '0;
            y1        <= '0;
            yt_q      <= '0;
            yb_q      <= '0;
            bx_q      <= '0;
            by0_q     <= '0;
            by1_q     <= '0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                px_q[i] <= '0;
                gt_q[i] <= '0;
                gb_q[i] <= '0;
            end
        end else begin
            k         <= k_n;
            c         <= c_n;
            seg_valid <= seg_valid_n;
            x0        <= x0_n;
            y0        <= y0_n;
            x1        <= x1_n;
            y1        <= y1_n;
            if (load) begin
                yt_q  <= y_top;
                yb_q  <= y_bot;
                bx_q  <= bird_x;
                by0_q <= bird_y0;
                by1_q <= bird_y1;
                for (int i = 0; i < NUM_PIPES; i++) begin
                    px_q[i] <= pipe_x[i*N +: N];
                    gt_q[i] <= pipe_gap_top[i*N +: N];
                    gb_q[i] <= pipe_gap_bot[i*N +: N];
                end
            end
        end
    end
endmodule

// File: tb/tb_segment_scheduler.sv
// Bench for segment_scheduler: directed frames plus randomized frames checked
// against a list-based model of the segments each frame should produce.
module tb_segment_scheduler;
    localparam int N  = 11;
    localparam int NP = 3;
    localparam int PW = 4;
    localparam int XM = 639;

    typedef struct packed {
        logic [N-1:0] x0;
        logic [N-1:0] y0;
        logic [N-1:0] x1;
        logic [N-1:0] y1;
    } seg_t;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            frame_start = 1'b0;
    logic [NP*N-1:0] pipe_x = '0;
    logic [NP*N-1:0] pipe_gap_top = '0;
    logic [NP*N-1:0] pipe_gap_bot = '0;
    logic [N-1:0]    y_top = '0;
    logic [N-1:0]    y_bot = '0;
    logic [N-1:0]    bird_x = '0;
    logic [N-1:0]    bird_y0 = '0;
    logic [N-1:0]    bird_y1 = '0;
    logic            clear_req;
    logic            clear_done = 1'b0;
    logic            seg_valid;
    logic            seg_ready = 1'b0;
    logic [N-1:0]    x0, y0, x1, y1;
    logic            busy;
    logic            frame_done;

    int total = 0;
    int bad = 0;
    seg_t exp_q[$];

    segment_scheduler #(.N(N), .NUM_PIPES(NP), .PIPE_W(PW), .X_MAX(XM)) dut (
        .clock(clock), .reset(reset), .frame_start(frame_start),
        .pipe_x(pipe_x), .pipe_gap_top(pipe_gap_top),
        .pipe_gap_bot(pipe_gap_bot), .y_top(y_top), .y_bot(y_bot),
        .bird_x(bird_x), .bird_y0(bird_y0), .bird_y1(bird_y1),
        .clear_req(clear_req), .clear_done(clear_done),
        .seg_valid(seg_valid), .seg_ready(seg_ready),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic seg_t mk(input int a, input int b, input int cc,
                                input int d);
        seg_t s;
        s.x0 = N'(a);
        s.y0 = N'(b);
        s.x1 = N'(cc);
        s.y1 = N'(d);
        return s;
    endfunction

    // Expected segment list, straight from the drawing rules.
    task automatic build_model();
        int px, col, gt, gb, yt, yb;
        exp_q.delete();
        exp_q.push_back(mk(bird_x, bird_y0, bird_x, bird_y1));
        yt = int'(y_top);
        yb = int'(y_bot);
        for (int p = 0; p < NP; p++) begin
            px = int'(pipe_x[p*N +: N]);
            gt = int'(pipe_gap_top[p*N +: N]);
            gb = int'(pipe_gap_bot[p*N +: N]);
            for (int cc = 0; cc < PW; cc++) begin
                col = px + cc;
                if (col <= XM) begin
                    if (gt >= yt) exp_q.push_back(mk(col, yt, col, gt));
                    if (gb <= yb) exp_q.push_back(mk(col, gb, col, yb));
                end
            end
        end
    endtask

    task automatic set_default();
        pipe_x       = {N'(500), N'(300), N'(100)};
        pipe_gap_top = {NP{N'(150)}};
        pipe_gap_bot = {NP{N'(250)}};
        y_top   = 0;
        y_bot   = 479;
        bird_x  = 50;
        bird_y0 = 200;
        bird_y1 = 215;
    endtask

    task automatic set_random();
        for (int p = 0; p < NP; p++) begin
            pipe_x[p*N +: N] = ($urandom_range(0, 7) == 0) ?
                N'($urandom_range(2040, 2047)) : N'($urandom_range(0, 700));
            pipe_gap_top[p*N +: N] = N'($urandom_range(0, 300));
            pipe_gap_bot[p*N +: N] = N'($urandom_range(150, 500));
        end
        y_top   = N'($urandom_range(0, 20));
        y_bot   = N'($urandom_range(440, 479));
        bird_x  = N'($urandom_range(0, 639));
        bird_y0 = N'($urandom_range(0, 479));
        bird_y1 = N'($urandom_range(0, 479));
    endtask

    // mode 0: ready always; 1: random ready; 2: stall 5 cycles on 3rd segment
    task automatic run_frame(input string nm, input int mode, input int exp_n,
                             input bit mid);
        int   acc, fd, stall, cyc;
        bit   held_v, rdy;
        seg_t held, cur, e;
        build_model();
        acc = 0; fd = 0; stall = 0; held_v = 0;
        @(negedge clock);
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        chk({nm, ":clear_req"}, 64'(clear_req), 64'd1);
        chk({nm, ":busy"}, 64'(busy), 64'd1);
        repeat ($urandom_range(0, 3)) @(negedge clock);
        chk({nm, ":clear_hold"}, 64'(clear_req), 64'd1);
        clear_done = 1'b1;
        @(negedge clock);
        clear_done = 1'b0;
        chk({nm, ":clear_drop"}, 64'(clear_req), 64'd0);
        for (cyc = 0; cyc < 2000; cyc++) begin
            cur = {x0, y0, x1, y1};
            if (frame_done) fd++;
            if (held_v) begin
                chk({nm, ":stall_valid"}, 64'(seg_valid), 64'd1);
                chk({nm, ":stall_seg"}, 64'(cur), 64'(held));
                held_v = 0;
            end
            if (!busy) break;
            if (mid && cyc == 6) begin
                pipe_x[N +: N] = N'($urandom_range(0, 600));
                pipe_x[0 +: N] = N'($urandom_range(0, 600));
                frame_start = 1'b1;
            end else begin
                frame_start = 1'b0;
            end
            case (mode)
                0: rdy = 1;
                1: rdy = 1'($urandom_range(0, 1));
                default: begin
                    rdy = 1;
                    if (seg_valid && acc == 2 && stall < 5) begin
                        rdy = 0;
                        stall++;
                    end
                end
            endcase
            seg_ready = rdy;
            if (seg_valid) begin
                if (rdy) begin
                    if (exp_q.size() == 0) begin
                        chk({nm, ":extra_seg"}, 64'(cur), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk({nm, ":seg"}, 64'(cur), 64'(e));
                    end
                    acc++;
                end else begin
                    held = cur;
                    held_v = 1;
                end
            end
            @(negedge clock);
        end
        frame_start = 1'b0;
        if (cyc >= 2000) chk({nm, ":timeout"}, 64'(cyc), 64'd0);
        chk({nm, ":frame_done_cnt"}, 64'(fd), 64'd1);
        chk({nm, ":missing"}, 64'(exp_q.size()), 64'd0);
        if (exp_n >= 0) chk({nm, ":seg_cnt"}, 64'(acc), 64'(exp_n));
        if (mode == 2) chk({nm, ":stall_cycles"}, 64'(stall), 64'd5);
    endtask

    initial begin
        int w;
        set_default();
        #12;
        chk("rst:seg_valid", 64'(seg_valid), 64'd0);
        chk("rst:clear_req", 64'(clear_req), 64'd0);
        chk("rst:busy", 64'(busy), 64'd0);
        chk("rst:frame_done", 64'(frame_done), 64'd0);
        chk("rst:endpoints", 64'({x0, y0, x1, y1}), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        // clear_done while idle must not start anything
        clear_done = 1'b1;
        @(negedge clock);
        clear_done = 1'b0;
        @(negedge clock);
        chk("idle_clear_done", 64'(busy), 64'd0);

        // abort a frame with reset while a segment is presented
        seg_ready = 1'b0;
        frame_start = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        clear_done = 1'b1;
        @(negedge clock);
        clear_done = 1'b0;
        w = 0;
        while (!seg_valid && w < 20) begin
            @(negedge clock);
            w++;
        end
        chk("abort:seg_valid_before", 64'(seg_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("abort:seg_valid", 64'(seg_valid), 64'd0);
        chk("abort:busy", 64'(busy), 64'd0);
        chk("abort:clear_req", 64'(clear_req), 64'd0);
        chk("abort:endpoints", 64'({x0, y0, x1, y1}), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        run_frame("after_abort", 0, 25, 0);
        run_frame("default", 0, 25, 0);
        run_frame("stall", 2, 25, 0);

        set_default();
        pipe_x = {N'(100), N'(2046), N'(638)};
        run_frame("xedge", 1, 13, 0);

        set_default();
        pipe_gap_top[0 +: N] = 0;
        y_top = 5;
        run_frame("gaptop", 1, 21, 0);

        set_default();
        run_frame("snapshot", 1, 25, 1);

        for (int i = 0; i < 12; i++) begin
            set_random();
            run_frame("rand", 1, -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
